// File: rtl/ps2_pkg.sv
// ---------------------------------------------------------------------------
// ps2_pkg
//   Shared definitions for the PS/2 host transmitter and the line
//   synchronizer: FSM state encoding, timer/counter widths, default timing
//   constants (50 MHz system clock) and frame-building helpers.
// ---------------------------------------------------------------------------
package ps2_pkg;

  // Transmitter FSM states.
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_INHIBIT  = 3'd1,
    ST_RTS      = 3'd2,
    ST_SEND     = 3'd3,
    ST_ACK      = 3'd4,
    ST_WAITIDLE = 3'd5
  } state_t;

  // Width of the shared down-timer; 20 bits covers the 15 ms start timeout.
  localparam int unsigned TIMER_W = 20;

  // Width of the device falling-edge counter (counts up to 11).
  localparam int unsigned EDGE_W = 4;

  // Bits shifted out by the host: 8 data + parity + stop.
  localparam int unsigned FRAME_BITS = 10;

  // Device clocks per host-to-device frame: 10 shifted bits + ACK clock.
  localparam int unsigned FRAME_CLOCKS = 11;

  // Default timing at 50 MHz.
  localparam int unsigned INHIBIT_CYCLES_DEF = 5000;    // 100 us
  localparam int unsigned START_TIMEOUT_DEF  = 750000;  // 15 ms
  localparam int unsigned BIT_TIMEOUT_DEF    = 100000;  // 2 ms

  // Odd parity: data plus parity bit carries an odd number of ones.
  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

  // Shift frame, LSB leaves first: D0..D7, parity, stop.
  function automatic logic [FRAME_BITS-1:0] make_frame(input logic [7:0] data);
    return {1'b1, odd_parity(data), data};
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// ---------------------------------------------------------------------------
// ps2_line_sync
//   Two-flop synchronizers for the raw ps2_clock / ps2_data pad inputs plus a
//   falling-edge strobe on the synchronized clock. Shared with the receive
//   path. Flops reset to 1 because both lines idle high.
//
// Ports
//   clock      in   system clock
//   resetn     in   asynchronous reset, active low
//   clk_pad    in   raw ps2_clock pad input (asynchronous)
//   data_pad   in   raw ps2_data pad input (asynchronous)
//   clk_sync   out  synchronized ps2_clock
//   data_sync  out  synchronized ps2_data
//   clk_fall   out  1-cycle strobe: synchronized ps2_clock went 1 -> 0
// ---------------------------------------------------------------------------
module ps2_line_sync (
  input  logic clock,
  input  logic resetn,
  input  logic clk_pad,
  input  logic data_pad,
  output logic clk_sync,
  output logic data_sync,
  output logic clk_fall
);

  logic [1:0] pad_vec;
  logic [1:0] sync_vec;
  logic       clk_prev_reg;

  assign pad_vec = {data_pad, clk_pad};

  // One identical synchronizer per line: bit 0 = clock, bit 1 = data.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_sync
      logic meta_reg;
      logic sync_reg;

      always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
          meta_reg <= 1'b1;
          sync_reg <= 1'b1;
        end else begin
          meta_reg <= pad_vec[gi];
          sync_reg <= meta_reg;
        end
      end

      assign sync_vec[gi] = sync_reg;
    end
  endgenerate

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      clk_prev_reg <= 1'b1;
    end else begin
      clk_prev_reg <= sync_vec[0];
    end
  end

  assign clk_sync  = sync_vec[0];
  assign data_sync = sync_vec[1];

  // Combinational strobe: the FSM acts on it at the third clock edge after
  // the pad transition.
  assign clk_fall = clk_prev_reg & ~sync_vec[0];

endmodule

// File: rtl/ps2_host_tx.sv
// ---------------------------------------------------------------------------
// ps2_host_tx
//   Host-to-device PS/2 transmitter. Sends one command byte: inhibits the
//   clock, issues request-to-send, shifts D0..D7, odd parity and stop on the
//   device's falling clock edges, then samples the device ACK on the 11th
//   edge and waits for both lines to return high. The pads are open-drain:
//   the *_oe outputs pull the line low when 1.
//
// Ports
//   clock        in   system clock (50 MHz)
//   resetn       in   asynchronous reset, active low
//   tx_data      in   command byte, captured on accept
//   tx_valid     in   request to send tx_data; held until tx_ready
//   tx_ready     out  high only in IDLE (and not during the tx_done cycle)
//   ps2_clk_in   in   raw ps2_clock pad input
//   ps2_data_in  in   raw ps2_data pad input
//   ps2_clk_oe   out  1 = pull ps2_clock low
//   ps2_data_oe  out  1 = pull ps2_data low
//   busy         out  high in every state except IDLE
//   tx_done      out  1-cycle pulse when the frame finishes (ACK or not)
//   ack_ok       out  1 = device acknowledged; holds until next accept
//   tx_error     out  1-cycle pulse on timeout or missing ACK
// ---------------------------------------------------------------------------
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = INHIBIT_CYCLES_DEF,
  parameter int unsigned START_TIMEOUT  = START_TIMEOUT_DEF,
  parameter int unsigned BIT_TIMEOUT    = BIT_TIMEOUT_DEF
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       tx_done,
  output logic       ack_ok,
  output logic       tx_error
);

  // Timer reload values: the timer counts N-1 down to 0, i.e. N cycles.
  localparam logic [TIMER_W-1:0] INHIBIT_LOAD = TIMER_W'(INHIBIT_CYCLES - 1);
  localparam logic [TIMER_W-1:0] START_LOAD   = TIMER_W'(START_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] BIT_LOAD     = TIMER_W'(BIT_TIMEOUT - 1);
  localparam logic [EDGE_W-1:0]  LAST_BIT_CNT = EDGE_W'(FRAME_BITS - 1);
  localparam logic [EDGE_W-1:0]  ACK_CNT      = EDGE_W'(FRAME_CLOCKS);

  state_t                state_reg, state_next;
  logic [TIMER_W-1:0]    timer_reg, timer_next;
  logic [EDGE_W-1:0]     edge_cnt_reg, edge_cnt_next;
  logic [FRAME_BITS-1:0] shift_reg, shift_next;

  logic clk_oe_reg,  clk_oe_next;
  logic data_oe_reg, data_oe_next;
  logic done_reg,    done_next;
  logic error_reg,   error_next;
  logic ack_reg,     ack_next;

  logic clk_sync;
  logic data_sync;
  logic clk_fall;

  logic accept;
  logic timer_zero;
  logic line_idle;
  logic timeout;

  ps2_line_sync u_sync (
    .clock     (clock),
    .resetn    (resetn),
    .clk_pad   (ps2_clk_in),
    .data_pad  (ps2_data_in),
    .clk_sync  (clk_sync),
    .data_sync (data_sync),
    .clk_fall  (clk_fall)
  );

  // Ready is withheld during the tx_done cycle so a queued request is
  // accepted one cycle after completion, never in the same cycle.
  assign tx_ready   = (state_reg == ST_IDLE) && !done_reg;
  assign busy       = (state_reg != ST_IDLE);
  assign accept     = tx_valid && tx_ready;
  assign timer_zero = (timer_reg == '0);
  assign line_idle  = clk_sync && data_sync;

  // A device edge (or the lines going idle) in the expiry cycle wins over
  // the timeout.
  always_comb begin : timeout_logic
    timeout = 1'b0;
    case (state_reg)
      ST_RTS, ST_SEND, ST_ACK: timeout = timer_zero && !clk_fall;
      ST_WAITIDLE:             timeout = timer_zero && !line_idle;
      default:                 timeout = 1'b0;
    endcase
  end

  // -------------------------------------------------------------------------
  // State and datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_reg    <= ST_IDLE;
      timer_reg    <= '0;
      edge_cnt_reg <= '0;
      shift_reg    <= '0;
      clk_oe_reg   <= 1'b0;
      data_oe_reg  <= 1'b0;
      done_reg     <= 1'b0;
      error_reg    <= 1'b0;
      ack_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      timer_reg    <= timer_next;
      edge_cnt_reg <= edge_cnt_next;
      shift_reg    <= shift_next;
      clk_oe_reg   <= clk_oe_next;
      data_oe_reg  <= data_oe_next;
      done_reg     <= done_next;
      error_reg    <= error_next;
      ack_reg      <= ack_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state and datapath logic
  // -------------------------------------------------------------------------
  always_comb begin : next_state_logic
    state_next    = state_reg;
    timer_next    = timer_reg;
    edge_cnt_next = edge_cnt_reg;
    shift_next    = shift_reg;

    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          state_next    = ST_INHIBIT;
          timer_next    = INHIBIT_LOAD;
          edge_cnt_next = '0;
          shift_next    = make_frame(tx_data);
        end
      end

      ST_INHIBIT: begin
        if (timer_zero) begin
          state_next = ST_RTS;
          timer_next = START_LOAD;
        end else begin
          timer_next = timer_reg - TIMER_W'(1);
        end
      end

      // RTS and SEND share the shift behaviour: each device falling edge
      // presents the next frame bit. Edge 10 puts the stop bit out.
      ST_RTS, ST_SEND: begin
        if (clk_fall) begin
          shift_next    = {1'b1, shift_reg[FRAME_BITS-1:1]};
          edge_cnt_next = edge_cnt_reg + EDGE_W'(1);
          timer_next    = BIT_LOAD;
          state_next    = (edge_cnt_reg == LAST_BIT_CNT) ? ST_ACK : ST_SEND;
        end else if (timeout) begin
          state_next = ST_IDLE;
        end else begin
          timer_next = timer_reg - TIMER_W'(1);
        end
      end

      ST_ACK: begin
        if (clk_fall) begin
          edge_cnt_next = ACK_CNT;
          timer_next    = BIT_LOAD;
          state_next    = ST_WAITIDLE;
        end else if (timeout) begin
          state_next = ST_IDLE;
        end else begin
          timer_next = timer_reg - TIMER_W'(1);
        end
      end

      ST_WAITIDLE: begin
        if (line_idle || timeout) begin
          state_next = ST_IDLE;
        end else begin
          timer_next = timer_reg - TIMER_W'(1);
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Output logic (next values of the registered outputs)
  // -------------------------------------------------------------------------
  always_comb begin : output_logic
    clk_oe_next  = (state_next == ST_INHIBIT);
    data_oe_next = data_oe_reg;
    done_next    = (state_reg != ST_IDLE) && (state_next == ST_IDLE);
    error_next   = 1'b0;
    ack_next     = ack_reg;

    case (state_reg)
      ST_IDLE: begin
        data_oe_next = 1'b0;
        if (accept) begin
          ack_next = 1'b0;
        end
      end

      // Start bit goes low in the last inhibit cycle, before the clock is
      // released, so the device sees a clean request-to-send.
      ST_INHIBIT: begin
        if (timer_reg <= TIMER_W'(1)) begin
          data_oe_next = 1'b1;
        end
      end

      // Open-drain: drive low for a 0 bit, release for a 1 bit.
      ST_RTS, ST_SEND: begin
        if (clk_fall) begin
          data_oe_next = ~shift_reg[0];
        end
      end

      ST_ACK: begin
        data_oe_next = 1'b0;
        if (clk_fall) begin
          if (data_sync) begin
            error_next = 1'b1;
          end else begin
            ack_next = 1'b1;
          end
        end
      end

      ST_WAITIDLE: begin
        data_oe_next = 1'b0;
      end

      default: begin
        data_oe_next = 1'b0;
      end
    endcase

    if (timeout) begin
      data_oe_next = 1'b0;
      error_next   = 1'b1;
      ack_next     = 1'b0;
    end
  end

  assign ps2_clk_oe  = clk_oe_reg;
  assign ps2_data_oe = data_oe_reg;
  assign tx_done     = done_reg;
  assign tx_error    = error_reg;
  assign ack_ok      = ack_reg;

endmodule

// File: tb/tb_ps2_host_tx.sv
`timescale 1ns/1ps
module tb_ps2_host_tx;

  localparam int INH = 50;
  localparam int ST  = 400;
  localparam int BT  = 120;
  localparam int HP  = 20;   // device half clock period in system cycles

  logic       clock    = 1'b0;
  logic       resetn   = 1'b0;
  logic [7:0] tx_data  = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       ps2_clk_oe;
  logic       ps2_data_oe;
  logic       busy;
  logic       tx_done;
  logic       ack_ok;
  logic       tx_error;

  logic dev_clk_low  = 1'b0;
  logic dev_data_low = 1'b0;
  logic ps2_clk_line;
  logic ps2_data_line;

  // Wired-AND open-drain lines with pull-ups.
  assign ps2_clk_line  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_line = ~(ps2_data_oe | dev_data_low);

  always #5 clock = ~clock;

  ps2_host_tx #(
    .INHIBIT_CYCLES (INH),
    .START_TIMEOUT  (ST),
    .BIT_TIMEOUT    (BT)
  ) dut (
    .clock       (clock),
    .resetn      (resetn),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .ps2_clk_in  (ps2_clk_line),
    .ps2_data_in (ps2_data_line),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe),
    .busy        (busy),
    .tx_done     (tx_done),
    .ack_ok      (ack_ok),
    .tx_error    (tx_error)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Expected wire frame as seen by the device: start, D0..D7, parity, stop.
  function automatic logic [10:0] model_frame(input logic [7:0] b);
    int ones = 0;
    logic [10:0] f;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = b[i];
    f[9]  = (ones % 2 == 0) ? 1'b1 : 1'b0;
    f[10] = 1'b1;
    return f;
  endfunction

  // ---------------------------------------------------------------------
  // Per-cycle monitor / compare process
  // ---------------------------------------------------------------------
  int   cyc = 0;
  int   done_cnt = 0;
  int   err_cnt = 0;
  int   last_done_cyc = -1;
  int   last_err_cyc = -1;
  int   rel_cyc = -1;
  int   inh_run = 0;
  logic done_ack = 1'b0;
  bit   m_busy = 1'b0;
  logic prev_done = 1'b0;
  logic prev_err = 1'b0;
  logic prev_clk_oe = 1'b0;
  int   acc_cyc[$];

  always @(negedge clock) begin
    cyc++;
    if (!resetn) begin
      m_busy      = 1'b0;
      inh_run     = 0;
      prev_done   = 1'b0;
      prev_err    = 1'b0;
      prev_clk_oe = 1'b0;
    end else begin
      check("busy", 32'(busy), 32'(m_busy && !tx_done));
      check("tx_ready", 32'(tx_ready), 32'(!m_busy && !tx_done));
      if (!busy) check("idle_lines", 32'({ps2_clk_oe, ps2_data_oe}), 32'(2'b00));
      if (prev_done) check("done_pulse", 32'(tx_done), 32'(1'b0));
      if (prev_err) check("error_pulse", 32'(tx_error), 32'(1'b0));
      if (ps2_clk_oe) begin
        inh_run++;
      end else if (prev_clk_oe) begin
        rel_cyc = cyc;
        check("inhibit_len", 32'(inh_run), 32'(INH));
        check("rts_start_bit", 32'(ps2_data_oe), 32'(1'b1));
        inh_run = 0;
      end
      if (tx_done) begin
        done_cnt++;
        last_done_cyc = cyc;
        done_ack = ack_ok;
        m_busy = 1'b0;
      end
      if (tx_error) begin
        err_cnt++;
        last_err_cyc = cyc;
      end
      if (tx_valid && tx_ready) begin
        m_busy = 1'b1;
        acc_cyc.push_back(cyc);
      end
      prev_done   = tx_done;
      prev_err    = tx_error;
      prev_clk_oe = ps2_clk_oe;
    end
  end

  // ---------------------------------------------------------------------
  // Host-side driver and device model
  // ---------------------------------------------------------------------
  task automatic submit(input logic [7:0] b, input bit keep, input logic [7:0] nb);
    int a0 = acc_cyc.size();
    int n = 0;
    tx_data  = b;
    tx_valid = 1'b1;
    while (acc_cyc.size() == a0 && n < 5000) begin
      tick();
      n++;
    end
    check("accept_seen", 32'(acc_cyc.size() > a0), 32'(1'b1));
    if (keep) tx_data = nb;
    else      tx_valid = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int limit);
    int n = 0;
    while (done_cnt == d0 && n < limit) begin
      tick();
      n++;
    end
    check("done_seen", 32'(done_cnt > d0), 32'(1'b1));
  endtask

  // Keyboard model: waits for request-to-send, produces `falls` clock
  // pulses, samples data on each rising edge, optionally ACKs on clock 11.
  task automatic dev_run(input int falls, input bit do_ack, input int delay,
                         output logic [10:0] seen);
    int n = 0;
    seen = '1;
    while (!(ps2_clk_oe === 1'b0 && ps2_data_line === 1'b0) && n < 3000) begin
      tick();
      n++;
    end
    check("rts_detect", 32'(n < 3000), 32'(1'b1));
    if (n >= 3000) return;
    repeat (delay) tick();
    seen[0] = ps2_data_line;
    for (int k = 1; k <= 10 && k <= falls; k++) begin
      dev_clk_low = 1'b1;
      repeat (HP) tick();
      dev_clk_low = 1'b0;
      seen[k] = ps2_data_line;
      repeat (HP) tick();
    end
    if (falls >= 11) begin
      if (do_ack) dev_data_low = 1'b1;
      repeat (2) tick();
      dev_clk_low = 1'b1;
      repeat (HP) tick();
      dev_clk_low = 1'b0;
      repeat (2) tick();
      dev_data_low = 1'b0;
      repeat (HP) tick();
    end
  endtask

  task automatic run_frame(input logic [7:0] b, input bit do_ack, input int delay,
                           output logic [10:0] seen);
    int d0 = done_cnt;
    int e0 = err_cnt;
    submit(b, 1'b0, 8'h00);
    dev_run(11, do_ack, delay, seen);
    check("wire_frame", 32'(seen), 32'(model_frame(b)));
    wait_done(d0, 500);
    check("done_count", 32'(done_cnt), 32'(d0 + 1));
    check("ack_ok", 32'(done_ack), 32'(do_ack));
    check("error_count", 32'(err_cnt), 32'(e0 + (do_ack ? 0 : 1)));
    if (!do_ack) check("nack_error_before_done", 32'(last_err_cyc < last_done_cyc), 32'(1'b1));
    $display("frame %02h ack=%0d wire=%b done_ack=%0b errors_so_far=%0d",
             b, do_ack, seen, done_ack, errors);
  endtask

  // ---------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------
  initial begin : main
    logic [10:0] seen, s1, s2;
    int d0, e0, a0, n, dcyc;
    logic [7:0] rb;
    bit rack;

    // Reset state
    #1;
    check("rst_tx_ready", 32'(tx_ready), 32'(1'b1));
    check("rst_busy", 32'(busy), 32'(1'b0));
    check("rst_oe", 32'({ps2_clk_oe, ps2_data_oe}), 32'(2'b00));
    check("rst_pulses", 32'({tx_done, tx_error, ack_ok}), 32'(3'b000));
    repeat (3) tick();
    resetn = 1'b1;
    repeat (5) tick();

    // Model pinned against hand-computed frames.
    check("model_ed", 32'(model_frame(8'hED)), 32'(11'b11111011010));
    check("model_f4", 32'(model_frame(8'hF4)), 32'(11'b10111101000));

    // 1) 0xED with ACK
    run_frame(8'hED, 1'b1, 30, seen);
    check("ed_wire_literal", 32'(seen), 32'(11'b11111011010));
    repeat (5) tick();

    // 2) 0xF4, parity 0 on the wire
    run_frame(8'hF4, 1'b1, 45, seen);
    check("f4_wire_literal", 32'(seen), 32'(11'b10111101000));
    repeat (5) tick();

    // 3) Device never clocks: start timeout
    d0 = done_cnt;
    e0 = err_cnt;
    submit(8'hF4, 1'b0, 8'h00);
    wait_done(d0, INH + ST + 50);
    check("timeout_done_count", 32'(done_cnt), 32'(d0 + 1));
    check("timeout_error_count", 32'(err_cnt), 32'(e0 + 1));
    check("timeout_latency", 32'(last_done_cyc - rel_cyc), 32'(ST));
    check("timeout_err_with_done", 32'(last_err_cyc), 32'(last_done_cyc));
    check("timeout_ack_ok", 32'(done_ack), 32'(1'b0));
    check("timeout_lines", 32'({ps2_clk_oe, ps2_data_oe}), 32'(2'b00));
    $display("frame f4 start-timeout latency=%0d", last_done_cyc - rel_cyc);
    repeat (5) tick();

    // 4) Device omits ACK
    run_frame(8'h5A, 1'b0, 25, seen);
    repeat (5) tick();

    // 5) Reset in the middle of the data bits
    d0 = done_cnt;
    submit(8'h00, 1'b0, 8'h00);
    dev_run(5, 1'b0, 20, seen);
    check("partial_wire", 32'(seen[5:0]), 32'(6'b000000));
    check("d4_driven", 32'(ps2_data_oe), 32'(1'b1));
    resetn = 1'b0;
    #1;
    check("midframe_rst_clk_oe", 32'(ps2_clk_oe), 32'(1'b0));
    check("midframe_rst_data_oe", 32'(ps2_data_oe), 32'(1'b0));
    repeat (3) tick();
    resetn = 1'b1;
    repeat (100) tick();
    check("post_rst_ready", 32'(tx_ready), 32'(1'b1));
    check("post_rst_busy", 32'(busy), 32'(1'b0));
    check("post_rst_no_done", 32'(done_cnt), 32'(d0));
    $display("frame 00 aborted by reset after data bit 4");

    // 6) Back-to-back requests with tx_valid held
    d0 = done_cnt;
    a0 = acc_cyc.size();
    submit(8'hED, 1'b1, 8'h02);
    dev_run(11, 1'b1, 30, s1);
    check("b2b_first_wire", 32'(s1), 32'(model_frame(8'hED)));
    wait_done(d0, 500);
    dcyc = last_done_cyc;
    n = 0;
    while (acc_cyc.size() < a0 + 2 && n < 20) begin
      tick();
      n++;
    end
    check("b2b_second_accept", 32'(acc_cyc.size() >= a0 + 2), 32'(1'b1));
    tx_valid = 1'b0;
    if (acc_cyc.size() >= a0 + 2)
      check("b2b_accept_after_done", 32'(acc_cyc[a0 + 1]), 32'(dcyc + 1));
    dev_run(11, 1'b1, 30, s2);
    check("b2b_second_wire", 32'(s2), 32'(model_frame(8'h02)));
    wait_done(d0 + 1, 500);
    check("b2b_ack_ok", 32'(done_ack), 32'(1'b1));
    $display("frames ed,02 back-to-back wire=%b,%b", s1, s2);
    repeat (5) tick();

    // Randomized frames
    for (int r = 0; r < 6; r++) begin
      rb   = 8'($urandom_range(0, 255));
      rack = ($urandom_range(0, 3) != 0);
      run_frame(rb, rack, int'($urandom_range(5, 80)), seen);
      repeat (int'($urandom_range(1, 10))) tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #800000;
    errors++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
